// File: rtl/sdram_arb_pkg.sv
// Shared types and constants for the SDRAM two-master port arbiter.
package sdram_arb_pkg;

  // Default watchdog span; must exceed controller power-up plus init time.
  localparam int unsigned DefaultTimeout = 16384;

  // Transfer size encodings (3 is reserved and forwarded unchanged).
  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StGap
  } arb_state_e;

  // One latched controller request.
  typedef struct packed {
    logic        rw;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
  } mem_req_t;

  // Fixed priority: the data port (m1) always wins. Returns 1 for m1.
  function automatic logic pick_fixed(input logic m0_req, input logic m1_req);
    pick_fixed = m1_req | ~m0_req;
  endfunction

  // Round robin: on a tie the master not granted last wins. Returns 1 for m1.
  function automatic logic pick_rr(input logic m0_req, input logic m1_req,
                                   input logic last_m1);
    if (m0_req && m1_req) begin
      pick_rr = ~last_m1;
    end else begin
      pick_rr = m1_req;
    end
  endfunction

endpackage

// File: rtl/sdram_arb_timer.sv
// Transaction watchdog: counts busy cycles, saturates at TIMEOUT-1 and
// flags expiry so the arbiter can abort a request the controller never completes.
module sdram_arb_timer
  import sdram_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT = DefaultTimeout
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign expire_o = (cnt_q == CntMax);

  // Next count: clear on grant, otherwise advance while enabled until expiry.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !expire_o) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Two-master arbiter in front of the SDRAM controller. Latches one request,
// holds it on the controller lines until data_valid (or watchdog expiry), then
// acks the granted master and idles one cycle before the next grant.
// Optional feature: define SDRAM_ARB_RR_EN for round-robin arbitration;
// otherwise m1 has fixed priority over m0.
module sdram_port_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT = DefaultTimeout
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic        m0_rw,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [1:0]  m0_size,
  output logic        m0_ack,
  output logic        m0_err,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  input  logic        m1_rw,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [1:0]  m1_size,
  output logic        m1_ack,
  output logic        m1_err,
  output logic [31:0] m1_rdata,
  output logic [31:0] mem_address,
  output logic        mem_rw_req,
  output logic        mem_rw,
  output logic [31:0] mem_write_data,
  output logic [1:0]  mem_size,
  input  logic [31:0] mem_read_data,
  input  logic        mem_data_valid
);

  arb_state_e  state_q, state_d;
  mem_req_t    mreq_q, mreq_d;
  logic        rw_req_q, rw_req_d;
  logic        grant_q, grant_d;   // 1 = m1 owns the current transaction
  logic        m0_ack_q, m0_ack_d, m1_ack_q, m1_ack_d;
  logic        m0_err_q, m0_err_d, m1_err_q, m1_err_d;
  logic [31:0] m0_rdata_q, m0_rdata_d, m1_rdata_q, m1_rdata_d;
  logic        pick;
  logic        timer_clr;
  logic        timer_en;
  logic        expire;
  mem_req_t    m0_in, m1_in;

`ifdef SDRAM_ARB_RR_EN
  logic        last_q, last_d;     // 1 = m1 was granted last
`endif

  assign m0_in = '{rw: m0_rw, addr: m0_addr, wdata: m0_wdata, size: m0_size};
  assign m1_in = '{rw: m1_rw, addr: m1_addr, wdata: m1_wdata, size: m1_size};

`ifdef SDRAM_ARB_RR_EN
  assign pick = pick_rr(m0_req, m1_req, last_q);
`else
  assign pick = pick_fixed(m0_req, m1_req);
`endif

  assign timer_en = (state_q == StBusy);

  sdram_arb_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .clr_i    (timer_clr),
    .en_i     (timer_en),
    .expire_o (expire)
  );

  // Next-state and registered-output logic for the grant/busy/gap sequence.
  always_comb begin
    state_d    = state_q;
    mreq_d     = mreq_q;
    rw_req_d   = rw_req_q;
    grant_d    = grant_q;
    m0_ack_d   = 1'b0;
    m1_ack_d   = 1'b0;
    m0_err_d   = 1'b0;
    m1_err_d   = 1'b0;
    m0_rdata_d = '0;
    m1_rdata_d = '0;
    timer_clr  = 1'b0;
`ifdef SDRAM_ARB_RR_EN
    last_d     = last_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (m0_req || m1_req) begin
          grant_d   = pick;
          mreq_d    = pick ? m1_in : m0_in;
          rw_req_d  = 1'b1;
          timer_clr = 1'b1;
          state_d   = StBusy;
`ifdef SDRAM_ARB_RR_EN
          last_d    = pick;
`endif
        end
      end
      StBusy: begin
        // data_valid takes precedence over a coincident watchdog expiry.
        if (mem_data_valid) begin
          rw_req_d = 1'b0;
          state_d  = StGap;
          if (grant_q) begin
            m1_ack_d   = 1'b1;
            m1_rdata_d = mem_read_data;
          end else begin
            m0_ack_d   = 1'b1;
            m0_rdata_d = mem_read_data;
          end
        end else if (expire) begin
          rw_req_d = 1'b0;
          state_d  = StGap;
          if (grant_q) begin
            m1_ack_d = 1'b1;
            m1_err_d = 1'b1;
          end else begin
            m0_ack_d = 1'b1;
            m0_err_d = 1'b1;
          end
        end
      end
      StGap: begin
        state_d = StIdle;
      end
      default: begin
        state_d  = StIdle;
        rw_req_d = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      mreq_q     <= '0;
      rw_req_q   <= 1'b0;
      grant_q    <= 1'b0;
      m0_ack_q   <= 1'b0;
      m1_ack_q   <= 1'b0;
      m0_err_q   <= 1'b0;
      m1_err_q   <= 1'b0;
      m0_rdata_q <= '0;
      m1_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      mreq_q     <= mreq_d;
      rw_req_q   <= rw_req_d;
      grant_q    <= grant_d;
      m0_ack_q   <= m0_ack_d;
      m1_ack_q   <= m1_ack_d;
      m0_err_q   <= m0_err_d;
      m1_err_q   <= m1_err_d;
      m0_rdata_q <= m0_rdata_d;
      m1_rdata_q <= m1_rdata_d;
    end
  end

`ifdef SDRAM_ARB_RR_EN
  // Round-robin pointer; reset value means m0 was granted last.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_q <= 1'b0;
    end else begin
      last_q <= last_d;
    end
  end
`endif

  assign mem_address    = mreq_q.addr;
  assign mem_rw         = mreq_q.rw;
  assign mem_write_data = mreq_q.wdata;
  assign mem_size       = mreq_q.size;
  assign mem_rw_req     = rw_req_q;
  assign m0_ack         = m0_ack_q;
  assign m1_ack         = m1_ack_q;
  assign m0_err         = m0_err_q;
  assign m1_err         = m1_err_q;
  assign m0_rdata       = m0_rdata_q;
  assign m1_rdata       = m1_rdata_q;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Bench for sdram_port_arbiter: transaction-level reference model checked every
// cycle, a simple controller model, and directed scenarios with literal checks.
module tb_sdram_port_arbiter;

  localparam int unsigned TO = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        m0_req = 1'b0, m0_rw = 1'b0, m1_req = 1'b0, m1_rw = 1'b0;
  logic [31:0] m0_addr = '0, m0_wdata = '0, m1_addr = '0, m1_wdata = '0;
  logic [1:0]  m0_size = '0, m1_size = '0;
  logic        m0_ack, m0_err, m1_ack, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic [31:0] mem_address, mem_write_data;
  logic        mem_rw_req, mem_rw;
  logic [1:0]  mem_size;
  logic [31:0] mem_read_data = '0;
  logic        mem_data_valid = 1'b0;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  sdram_port_arbiter #(
    .TIMEOUT (TO)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .m0_req         (m0_req),
    .m0_rw          (m0_rw),
    .m0_addr        (m0_addr),
    .m0_wdata       (m0_wdata),
    .m0_size        (m0_size),
    .m0_ack         (m0_ack),
    .m0_err         (m0_err),
    .m0_rdata       (m0_rdata),
    .m1_req         (m1_req),
    .m1_rw          (m1_rw),
    .m1_addr        (m1_addr),
    .m1_wdata       (m1_wdata),
    .m1_size        (m1_size),
    .m1_ack         (m1_ack),
    .m1_err         (m1_err),
    .m1_rdata       (m1_rdata),
    .mem_address    (mem_address),
    .mem_rw_req     (mem_rw_req),
    .mem_rw         (mem_rw),
    .mem_write_data (mem_write_data),
    .mem_size       (mem_size),
    .mem_read_data  (mem_read_data),
    .mem_data_valid (mem_data_valid)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic bound_fail(input string name);
    total++;
    bad++;
    $display("FAIL %s: wait bound expired at %0t", name, $time);
  endtask

  // Controller model: data_valid ctl_delay cycles after rw_req is seen; 0 = never.
  int          ctl_delay = 0;
  logic [31:0] ctl_data = '0;
  int          ctl_cnt = 0;
  initial forever begin
    @(negedge clk);
    mem_data_valid = 1'b0;
    mem_read_data  = ctl_data;
    if (reset || !mem_rw_req) begin
      ctl_cnt = 0;
    end else begin
      ctl_cnt++;
      if (ctl_delay > 0 && ctl_cnt == ctl_delay) mem_data_valid = 1'b1;
    end
  end

  // Reference model: who owns the port, how long it has been outstanding, and
  // whether the mandatory idle cycle after a completion is still pending.
  int          m_owner = -1;
  int          m_age = 0;
  int          m_last = 0;
  bit          m_cool = 1'b0;
  logic        e_req = 1'b0, e_rw = 1'b0;
  logic [31:0] e_addr = '0, e_wd = '0, e_rd0 = '0, e_rd1 = '0;
  logic [1:0]  e_size = '0, e_ack = '0, e_err = '0;

  always @(posedge clk or posedge reset) begin : model
    int o, a, l;
    bit c;
    logic [1:0]  ack_n, err_n;
    logic [31:0] rd0_n, rd1_n;
    if (reset) begin
      m_owner <= -1; m_age <= 0; m_cool <= 1'b0; m_last <= 0;
      e_req <= 1'b0; e_rw <= 1'b0; e_addr <= '0; e_wd <= '0; e_size <= '0;
      e_ack <= '0; e_err <= '0; e_rd0 <= '0; e_rd1 <= '0;
    end else begin
      o = m_owner; a = m_age; c = m_cool; l = m_last;
      ack_n = '0; err_n = '0; rd0_n = '0; rd1_n = '0;
      if (o >= 0) begin
        if (mem_data_valid || a == TO - 1) begin
          ack_n[o] = 1'b1;
          err_n[o] = !mem_data_valid;
          if (mem_data_valid) begin
            if (o == 0) rd0_n = mem_read_data;
            else rd1_n = mem_read_data;
          end
          o = -1;
          c = 1'b1;
          e_req <= 1'b0;
        end else begin
          a++;
        end
      end else if (c) begin
        c = 1'b0;
      end else if (m0_req || m1_req) begin
`ifdef SDRAM_ARB_RR_EN
        if (m0_req && m1_req) o = 1 - l;
        else o = m1_req ? 1 : 0;
`else
        o = m1_req ? 1 : 0;
`endif
        l = o;
        a = 0;
        e_req <= 1'b1;
        if (o == 1) begin
          e_rw <= m1_rw; e_addr <= m1_addr; e_wd <= m1_wdata; e_size <= m1_size;
        end else begin
          e_rw <= m0_rw; e_addr <= m0_addr; e_wd <= m0_wdata; e_size <= m0_size;
        end
      end
      m_owner <= o; m_age <= a; m_cool <= c; m_last <= l;
      e_ack <= ack_n; e_err <= err_n; e_rd0 <= rd0_n; e_rd1 <= rd1_n;
    end
  end

  // Every-cycle comparison of all DUT outputs against the model.
  always @(negedge clk) begin
    chk("mem_rw_req", mem_rw_req, e_req);
    chk("mem_rw", mem_rw, e_rw);
    chk("mem_address", mem_address, e_addr);
    chk("mem_write_data", mem_write_data, e_wd);
    chk("mem_size", mem_size, e_size);
    chk("m0_ack", m0_ack, e_ack[0]);
    chk("m1_ack", m1_ack, e_ack[1]);
    chk("m0_err", m0_err, e_err[0]);
    chk("m1_err", m1_err, e_err[1]);
    chk("m0_rdata", m0_rdata, e_rd0);
    chk("m1_rdata", m1_rdata, e_rd1);
  end

  task automatic wait_ack(input int m, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!((m == 0) ? m0_ack : m1_ack) && n < 200);
    if (!((m == 0) ? m0_ack : m1_ack)) bound_fail((m == 0) ? "wait_m0_ack" : "wait_m1_ack");
  endtask

  task automatic wait_req(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!mem_rw_req && n < 200);
    if (!mem_rw_req) bound_fail("wait_mem_rw_req");
  endtask

  initial begin : global_bound
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin : stim
    int n;
    int first;
    repeat (3) @(negedge clk);
    chk("rst_mem_rw_req", mem_rw_req, 0);
    chk("rst_mem_address", mem_address, 0);
    chk("rst_m0_ack", m0_ack, 0);
    reset = 1'b0;
    @(negedge clk);

    // Single m0 word read.
    ctl_delay = 9; ctl_data = 32'hDEADBEEF;
    m0_req = 1'b1; m0_rw = 1'b0; m0_addr = 32'h0003_0010; m0_size = 2'd2;
    wait_ack(0, n);
    chk("t1_latency", n, 10);
    chk("t1_m0_rdata", m0_rdata, 32'hDEADBEEF);
    chk("t1_rw_req_low", mem_rw_req, 0);
    chk("t1_m1_ack", m1_ack, 0);
    chk("t1_m1_rdata", m1_rdata, 0);
    m0_req = 1'b0;
    @(negedge clk);

    // Simultaneous requests: m1 wins (fixed priority, or RR with m0 last).
    ctl_delay = 3;
    m0_req = 1'b1; m0_rw = 1'b0; m0_addr = 32'h0003_0000; m0_size = 2'd2;
    m1_req = 1'b1; m1_rw = 1'b1; m1_addr = 32'h0003_0100; m1_wdata = 32'h1234_5678;
    m1_size = 2'd2;
    wait_req(n);
    chk("t2_first_addr", mem_address, 32'h0003_0100);
    chk("t2_first_rw", mem_rw, 1);
    chk("t2_first_wdata", mem_write_data, 32'h1234_5678);
    wait_ack(1, n);
    m1_req = 1'b0;
    wait_req(n);
    chk("t2_regrant_gap", n, 2);
    chk("t2_second_addr", mem_address, 32'h0003_0000);
    wait_ack(0, n);
    m0_req = 1'b0;
    @(negedge clk);

    // m1 byte write, fields held stable mid-transaction.
    ctl_delay = 6;
    m1_req = 1'b1; m1_rw = 1'b1; m1_addr = 32'h0003_0003; m1_wdata = 32'h0000_00A5;
    m1_size = 2'd0;
    wait_req(n);
    repeat (3) @(negedge clk);
    chk("t3_size", mem_size, 0);
    chk("t3_addr", mem_address, 32'h0003_0003);
    chk("t3_wdata", mem_write_data, 32'h0000_00A5);
    chk("t3_rw_req_held", mem_rw_req, 1);
    wait_ack(1, n);
    chk("t3_m1_err", m1_err, 0);
    m1_req = 1'b0;
    @(negedge clk);

    // Second simultaneous pair after an m1 grant: RR gives m0, fixed gives m1.
    ctl_delay = 3;
    m0_req = 1'b1; m0_rw = 1'b0; m0_addr = 32'h0003_0000; m0_size = 2'd1;
    m1_req = 1'b1; m1_rw = 1'b0; m1_addr = 32'h0003_0104; m1_size = 2'd1;
    wait_req(n);
`ifdef SDRAM_ARB_RR_EN
    first = 0;
    chk("t4_first_addr", mem_address, 32'h0003_0000);
`else
    first = 1;
    chk("t4_first_addr", mem_address, 32'h0003_0104);
`endif
    wait_ack(first, n);
    if (first == 0) m0_req = 1'b0; else m1_req = 1'b0;
    wait_ack(1 - first, n);
    m0_req = 1'b0; m1_req = 1'b0;
    @(negedge clk);

    // Watchdog expiry: controller never answers.
    ctl_delay = 0; ctl_data = 32'h5555_AAAA;
    m0_req = 1'b1; m0_rw = 1'b0; m0_addr = 32'h0003_0020; m0_size = 2'd2;
    wait_req(n);
    m1_req = 1'b1; m1_rw = 1'b0; m1_addr = 32'h0003_0200; m1_size = 2'd2;
    wait_ack(0, n);
    chk("t5_timeout_cycles", n, 16);
    chk("t5_m0_err", m0_err, 1);
    chk("t5_m0_rdata", m0_rdata, 0);
    chk("t5_rw_req_low", mem_rw_req, 0);
    m0_req = 1'b0;
    ctl_delay = 4;
    wait_req(n);
    chk("t5_gap_before_regrant", n, 2);
    wait_ack(1, n);
    chk("t5_m1_err", m1_err, 0);
    m1_req = 1'b0;
    @(negedge clk);

    // data_valid coincident with watchdog expiry: normal completion.
    ctl_delay = 16; ctl_data = 32'hCAFE_F00D;
    m1_req = 1'b1; m1_rw = 1'b0; m1_addr = 32'h0003_0300; m1_size = 2'd1;
    wait_ack(1, n);
    chk("t6_latency", n, 17);
    chk("t6_m1_err", m1_err, 0);
    chk("t6_m1_rdata", m1_rdata, 32'hCAFE_F00D);
    m1_req = 1'b0;
    @(negedge clk);

    // Reset in the middle of a transaction; held m0_req re-granted afterwards.
    ctl_delay = 8; ctl_data = 32'h0BAD_F00D;
    m0_req = 1'b1; m0_rw = 1'b0; m0_addr = 32'h0003_0040; m0_size = 2'd2;
    wait_req(n);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("t7_async_drop", mem_rw_req, 0);
    chk("t7_async_addr", mem_address, 0);
    chk("t7_no_ack", m0_ack, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("t7_regrant", mem_rw_req, 1);
    chk("t7_regrant_addr", mem_address, 32'h0003_0040);
    wait_ack(0, n);
    chk("t7_m0_rdata", m0_rdata, 32'h0BAD_F00D);
    m0_req = 1'b0;

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
